us_alarm_sched: RTL and testbench

Microsecond time base plus NCH programmable alarm channels, shared by the J1 core over its 16-bit I/O bus. The block prescales clk to a 1 µs tick, runs a free-running 32-bit µs counter, and schedules one-shot or periodic alarms. Alarms set pending flags and a masked, level interrupt. It sits on the CPU I/O decode beside the other peripherals.

---
 rtl/us_sched_pkg.sv | 22 ++
 rtl/us_alarm_chan.sv | 48 ++++
 rtl/us_alarm_sched.sv | 121 ++++++++++++
 tb/tb_us_alarm_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/us_sched_pkg.sv
// Shared constants for the microsecond alarm scheduler: register map,
// CH_CTRL bit positions and the per-channel state encoding.
package us_sched_pkg;

  localparam logic [3:0] ADDR_TIME_LO = 4'd0;
  localparam logic [3:0] ADDR_TIME_HI = 4'd1;
  localparam logic [3:0] ADDR_PEND    = 4'd2;
  localparam logic [3:0] ADDR_MASK    = 4'd3;
  localparam logic [3:0] ADDR_CH_BASE = 4'd4;

  localparam int unsigned CTRL_ARM = 0;
  localparam int unsigned CTRL_PER = 1;

  localparam int unsigned IO_W   = 16;
  localparam int unsigned TIME_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } ch_state_e;

endpackage

// File: rtl/us_alarm_chan.sv
// One alarm channel: IDLE/ARMED state, 16-bit microsecond down counter and
// a combinational fire pulse on the tick that expires the count.
module us_alarm_chan
  import us_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        ctrl_wr,
  input  logic        arm_bit,
  input  logic        per_bit,
  input  logic [15:0] period,
  output logic        armed,
  output logic        periodic,
  output logic        fire_c
);

  ch_state_e   state;
  logic [15:0] cnt;

  assign armed  = (state == ST_ARMED);
  // A control write in the same cycle pre-empts the tick, so it also pre-empts the fire.
  assign fire_c = (state == ST_ARMED) && tick && (cnt == 16'd1) && !ctrl_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      periodic <= 1'b0;
    end else if (ctrl_wr) begin
      periodic <= per_bit;
      if (arm_bit && (period != 16'd0)) begin
        state <= ST_ARMED;
        cnt   <= period;
      end else begin
        state <= ST_IDLE;
      end
    end else if ((state == ST_ARMED) && tick) begin
      if (cnt == 16'd1) begin
        if (periodic) cnt <= period;
        else          state <= ST_IDLE;
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

endmodule

// File: rtl/us_alarm_sched.sv
// Microsecond time base with NCH alarm channels on the 16-bit I/O bus.
// Optional US_TIME_LATCH_EN: a TIME_LO read latches time[31:16] for TIME_HI.
module us_alarm_sched
  import us_sched_pkg::*;
#(
  parameter int unsigned MHz = 25,
  parameter int unsigned NCH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  io_addr,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [15:0] io_din,
  output logic [15:0] io_dout,
  output logic        tick_us,
  output logic        irq
);

  localparam int unsigned DIV_W = 6;

  logic [DIV_W-1:0]           div;
  logic [TIME_W-1:0]          time_q;
  logic [NCH-1:0]             pend;
  logic [NCH-1:0]             mask;
  logic [NCH-1:0]             fire;
  logic [NCH-1:0]             armed;
  logic [NCH-1:0]             periodic;
  logic [NCH-1:0][IO_W-1:0]   per_rd;
  logic [IO_W-1:0]            rd_data_c;
  logic                       pend_wr_c;

  // tick_us is registered one cycle early so it is high exactly while div==MHz-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= '0;
      tick_us <= 1'b0;
      time_q  <= '0;
    end else begin
      tick_us <= (div == DIV_W'(MHz - 2));
      div     <= (div == DIV_W'(MHz - 1)) ? '0 : div + DIV_W'(1);
      if (tick_us) time_q <= time_q + TIME_W'(1);
    end
  end

`ifdef US_TIME_LATCH_EN
  logic [15:0] time_hi_shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  time_hi_shadow <= '0;
    else if (io_rd && io_addr == ADDR_TIME_LO) time_hi_shadow <= time_q[31:16];
  end
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [3:0] ADDR_PER = ADDR_CH_BASE + 4'(2 * c);
    localparam logic [3:0] ADDR_CTL = ADDR_PER + 4'd1;

    logic [15:0] period_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                              period_q <= '0;
      else if (io_wr && io_addr == ADDR_PER) period_q <= io_din;
    end

    assign per_rd[c] = period_q;

    us_alarm_chan u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick_us),
      .ctrl_wr  (io_wr && io_addr == ADDR_CTL),
      .arm_bit  (io_din[CTRL_ARM]),
      .per_bit  (io_din[CTRL_PER]),
      .period   (period_q),
      .armed    (armed[c]),
      .periodic (periodic[c]),
      .fire_c   (fire[c])
    );
  end

  // Read mux sees pre-write state, so a simultaneous write never leaks into the read.
  always_comb begin
    rd_data_c = '0;
    case (io_addr)
      ADDR_TIME_LO: rd_data_c = time_q[15:0];
`ifdef US_TIME_LATCH_EN
      ADDR_TIME_HI: rd_data_c = time_hi_shadow;
`else
      ADDR_TIME_HI: rd_data_c = time_q[31:16];
`endif
      ADDR_PEND:    rd_data_c = IO_W'(pend);
      ADDR_MASK:    rd_data_c = IO_W'(mask);
      default: begin
        for (int c = 0; c < NCH; c++) begin
          if (io_addr == ADDR_CH_BASE + 4'(2 * c))        rd_data_c = per_rd[c];
          if (io_addr == ADDR_CH_BASE + 4'(2 * c) + 4'd1) rd_data_c = IO_W'({periodic[c], armed[c]});
        end
      end
    endcase
  end

  assign pend_wr_c = io_wr && (io_addr == ADDR_PEND);

  // A fire in the same cycle as its write-1-to-clear keeps the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= '0;
      mask    <= '0;
      irq     <= 1'b0;
      io_dout <= '0;
    end else begin
      irq <= |(pend & mask);
      if (pend_wr_c) pend <= (pend & ~io_din[NCH-1:0]) | fire;
      else           pend <= pend | fire;
      if (io_wr && io_addr == ADDR_MASK) mask <= io_din[NCH-1:0];
      if (io_rd) io_dout <= rd_data_c;
    end
  end

endmodule

// File: tb/tb_us_alarm_sched.sv
// Self-checking bench for us_alarm_sched against an edge-scheduled alarm model.
module tb_us_alarm_sched;
  import us_sched_pkg::*;

  localparam int unsigned MHZ = 25;
  localparam int unsigned NCH = 4;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic [3:0]  io_addr = '0;
  logic        io_wr   = 1'b0;
  logic        io_rd   = 1'b0;
  logic [15:0] io_din  = '0;
  logic [15:0] io_dout;
  logic        tick_us;
  logic        irq;

  always #5 clk = ~clk;

  us_alarm_sched #(.MHz(MHZ), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_wr(io_wr), .io_rd(io_rd),
    .io_din(io_din), .io_dout(io_dout), .tick_us(tick_us), .irq(irq)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Model: e counts clock edges since reset; tick k lands on edge k*MHZ, and an
  // armed channel fires on the edge of its scheduled tick (m_next).
  int unsigned    e;
  int unsigned    m_tick;
  int unsigned    m_off = 0;
  logic [15:0]    m_dout;
  logic [NCH-1:0] m_pend;
  logic [NCH-1:0] m_mask;
  logic           m_irq;
  logic [15:0]    m_period [NCH];
  logic           m_per    [NCH];
  logic           m_armed  [NCH];
  int unsigned    m_next   [NCH];
`ifdef US_TIME_LATCH_EN
  logic [15:0]    m_shadow;
`endif

  function automatic logic [3:0] a_per(input int c);
    return 4'(4 + 2 * c);
  endfunction

  function automatic logic [3:0] a_ctl(input int c);
    return 4'(5 + 2 * c);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [NCH-1:0] fire;
    logic [15:0]    rd;
    logic [31:0]    now;
    if (rst) begin
      e = 0; m_tick = 0; m_dout = '0; m_pend = '0; m_mask = '0; m_irq = 1'b0;
`ifdef US_TIME_LATCH_EN
      m_shadow = '0;
`endif
      for (int c = 0; c < NCH; c++) begin
        m_period[c] = '0; m_per[c] = 1'b0; m_armed[c] = 1'b0; m_next[c] = 0;
      end
    end else begin
      e++;
      now = 32'(m_off + m_tick);
      rd  = '0;
      case (io_addr)
        4'd0: rd = now[15:0];
`ifdef US_TIME_LATCH_EN
        4'd1: rd = m_shadow;
`else
        4'd1: rd = now[31:16];
`endif
        4'd2: rd = 16'(m_pend);
        4'd3: rd = 16'(m_mask);
        default:
          for (int c = 0; c < NCH; c++) begin
            if (io_addr == a_per(c)) rd = m_period[c];
            if (io_addr == a_ctl(c)) rd = {14'd0, m_per[c], m_armed[c]};
          end
      endcase
      m_irq = |(m_pend & m_mask);
      fire = '0;
      for (int c = 0; c < NCH; c++) begin
        if (m_armed[c] && m_next[c] == e && !(io_wr && io_addr == a_ctl(c))) begin
          fire[c] = 1'b1;
          if (m_per[c]) m_next[c] = m_next[c] + 32'(m_period[c]) * MHZ;
          else          m_armed[c] = 1'b0;
        end
      end
      if (io_wr) begin
        if (io_addr == 4'd2) m_pend = m_pend & ~io_din[NCH-1:0];
        if (io_addr == 4'd3) m_mask = io_din[NCH-1:0];
        for (int c = 0; c < NCH; c++) begin
          if (io_addr == a_per(c)) m_period[c] = io_din;
          if (io_addr == a_ctl(c)) begin
            m_per[c] = io_din[1];
            if (io_din[0] && m_period[c] != 16'd0) begin
              m_armed[c] = 1'b1;
              m_next[c]  = (e / MHZ + 32'(m_period[c])) * MHZ;
            end else begin
              m_armed[c] = 1'b0;
            end
          end
        end
      end
      m_pend = m_pend | fire;
`ifdef US_TIME_LATCH_EN
      if (io_rd && io_addr == 4'd0) m_shadow = now[31:16];
`endif
      if (io_rd) m_dout = rd;
      if (e % MHZ == 0) m_tick++;
    end
  end

  task automatic io_write(input logic [3:0] a, input logic [15:0] d);
    io_addr = a; io_din = d; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic io_read(input logic [3:0] a, output logic [15:0] d);
    io_addr = a; io_rd = 1'b1;
    @(negedge clk);
    io_rd = 1'b0;
    d = io_dout;
  endtask

  task automatic test_reset();
    int unsigned n;
    logic [15:0] d;
    rst = 1'b1; m_off = 0;
    repeat (3) @(negedge clk);
    n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
    n_total++; if (tick_us !== 1'b0) $display("FAIL reset_tick: got %b want 0", tick_us); else n_pass++;
    n_total++; if (io_dout !== 16'h0) $display("FAIL reset_dout: got %h want 0000", io_dout); else n_pass++;
    rst = 1'b0;
    n = 0;
    do begin @(posedge clk); n++; #1; end while (!tick_us && n < 4 * MHZ);
    n_total++; if (n != MHZ - 1) $display("FAIL first_tick: got edge %0d want %0d", n, MHZ - 1); else n_pass++;
    @(negedge clk);
    while (e < 100) @(negedge clk);
    io_read(ADDR_TIME_LO, d);
    n_total++; if (d !== 16'(100 / MHZ)) $display("FAIL time_lo_100: got %h want %h", d, 16'(100 / MHZ)); else n_pass++;
    for (int i = 0; i < 3 * MHZ; i++) begin
      n_total++;
      if (tick_us !== ((e + 1) % MHZ == 0)) $display("FAIL tick_cadence: got %b at edge %0d", tick_us, e);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_oneshot();
    int unsigned fe, n;
    logic [15:0] d;
    io_write(ADDR_MASK, 16'h0001);
    io_write(a_per(0), 16'd3);
    io_write(a_ctl(0), 16'h0001);
    fe = (e / MHZ + 3) * MHZ;
    n = 0;
    while (irq !== 1'b1 && n < 5 * MHZ) begin @(negedge clk); n++; end
    n_total++; if (e != fe + 1) $display("FAIL oneshot_irq_edge: got %0d want %0d", e, fe + 1); else n_pass++;
    io_read(ADDR_PEND, d);
    n_total++; if (d !== 16'h0001) $display("FAIL oneshot_pend: got %h want 0001", d); else n_pass++;
    io_read(a_ctl(0), d);
    n_total++; if (d !== 16'h0000) $display("FAIL oneshot_idle: got %h want 0000", d); else n_pass++;
    io_write(ADDR_PEND, 16'h0001);
    n_total++; if (irq !== 1'b1) $display("FAIL irq_lag: got %b want 1", irq); else n_pass++;
    @(negedge clk);
    n_total++; if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq); else n_pass++;
    repeat (10 * MHZ) @(negedge clk);
    io_read(ADDR_PEND, d);
    n_total++; if (d !== 16'h0000) $display("FAIL oneshot_no_refire: got %h want 0000", d); else n_pass++;
  endtask

  task automatic test_periodic();
    int unsigned n, prev;
    logic [15:0] d;
    io_write(ADDR_MASK, 16'h0002);
    io_write(a_per(1), 16'd2);
    io_write(a_ctl(1), 16'h0003);
    n = 0;
    while (e + 1 != m_next[1] && n < 4 * MHZ) begin @(negedge clk); n++; end
    io_write(ADDR_PEND, 16'h0002);
    io_read(ADDR_PEND, d);
    n_total++; if (d !== 16'h0002) $display("FAIL clear_vs_fire: got %h want 0002", d); else n_pass++;
    io_write(ADDR_PEND, 16'h0002);
    @(negedge clk);
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (irq !== 1'b1 && n < 4 * MHZ) begin @(negedge clk); n++; end
      if (k > 0) begin
        n_total++;
        if (e - prev != 2 * MHZ) $display("FAIL periodic_interval: got %0d want %0d", e - prev, 2 * MHZ);
        else n_pass++;
      end
      prev = e;
      io_write(ADDR_PEND, 16'h0002);
      @(negedge clk);
    end
    n = 0;
    while (irq !== 1'b1 && n < 4 * MHZ) begin @(negedge clk); n++; end
    io_write(a_ctl(1), 16'h0000);
    repeat (5 * MHZ) @(negedge clk);
    io_read(ADDR_PEND, d);
    n_total++; if (d !== 16'h0002) $display("FAIL pend_retained: got %h want 0002", d); else n_pass++;
    io_read(a_ctl(1), d);
    n_total++; if (d !== 16'h0000) $display("FAIL disarm_ctrl: got %h want 0000", d); else n_pass++;
    io_write(ADDR_PEND, 16'h0002);
    repeat (5 * MHZ) @(negedge clk);
    io_read(ADDR_PEND, d);
    n_total++; if (d !== 16'h0000) $display("FAIL disarm_no_fire: got %h want 0000", d); else n_pass++;
  endtask

  task automatic test_zero_and_rearm();
    int unsigned ea, t3, off, fe, n;
    logic [15:0] d;
    io_write(ADDR_MASK, 16'h0004);
    io_write(a_per(2), 16'd0);
    io_write(a_ctl(2), 16'h0001);
    io_read(a_ctl(2), d);
    n_total++; if (d !== 16'h0000) $display("FAIL zero_period_ctrl: got %h want 0000", d); else n_pass++;
    repeat (6 * MHZ) @(negedge clk);
    io_read(ADDR_PEND, d);
    n_total++; if (d !== 16'h0000) $display("FAIL zero_period_nofire: got %h want 0000", d); else n_pass++;
    io_write(a_per(2), 16'd5);
    repeat ($urandom_range(0, MHZ - 1)) @(negedge clk);
    io_write(a_ctl(2), 16'h0001);
    ea  = e;
    t3  = (ea / MHZ + 3) * MHZ;
    off = $urandom_range(1, MHZ - 1);
    while (e + 1 < t3 + off) @(negedge clk);
    io_write(a_ctl(2), 16'h0001);
    fe = (ea / MHZ + 8) * MHZ;
    n = 0;
    while (irq !== 1'b1 && n < 12 * MHZ) begin @(negedge clk); n++; end
    n_total++; if (e != fe + 1) $display("FAIL rearm_fire_edge: got %0d want %0d", e, fe + 1); else n_pass++;
    io_write(ADDR_PEND, 16'h0004);
    @(negedge clk);
  endtask

  task automatic test_time_wrap();
    logic [15:0] d;
    while (e % MHZ != 0) @(negedge clk);
    force dut.time_q = 32'h0000_FFFF;
    m_off = 32'h0000_FFFF - m_tick;
    #1 release dut.time_q;
    repeat (MHZ) @(negedge clk);
    io_read(ADDR_TIME_LO, d);
    n_total++; if (d !== 16'h0000) $display("FAIL wrap_lo: got %h want 0000", d); else n_pass++;
    io_read(ADDR_TIME_HI, d);
    n_total++; if (d !== 16'h0001) $display("FAIL wrap_hi: got %h want 0001", d); else n_pass++;
    while (e % MHZ != 0) @(negedge clk);
    force dut.time_q = 32'h0000_FFFF;
    m_off = 32'h0000_FFFF - m_tick;
    #1 release dut.time_q;
    @(negedge clk);
    io_read(ADDR_TIME_LO, d);
    n_total++; if (d !== 16'hFFFF) $display("FAIL latch_lo: got %h want ffff", d); else n_pass++;
    repeat (MHZ) @(negedge clk);
    io_read(ADDR_TIME_HI, d);
`ifdef US_TIME_LATCH_EN
    n_total++; if (d !== 16'h0000) $display("FAIL latch_hi: got %h want 0000", d); else n_pass++;
`else
    n_total++; if (d !== 16'h0001) $display("FAIL live_hi: got %h want 0001", d); else n_pass++;
`endif
  endtask

  task automatic test_random();
    int unsigned r;
    logic [3:0]  a;
    for (int i = 0; i < 3000; i++) begin
      n_total++; if (irq !== m_irq) $display("FAIL rand_irq: got %b want %b at edge %0d", irq, m_irq, e); else n_pass++;
      n_total++; if (io_dout !== m_dout) $display("FAIL rand_dout: got %h want %h at edge %0d", io_dout, m_dout, e); else n_pass++;
      n_total++; if (tick_us !== ((e + 1) % MHZ == 0)) $display("FAIL rand_tick: got %b at edge %0d", tick_us, e); else n_pass++;
      io_wr = 1'b0; io_rd = 1'b0;
      r = $urandom_range(0, 9);
      a = 4'($urandom_range(0, 15));
      io_addr = a;
      if (r <= 2) begin
        io_wr = 1'b1;
        if (a >= 4'd4 && a[0] == 1'b0 && 32'(a) < 4 + 2 * NCH) io_din = 16'($urandom_range(0, 4));
        else                                                    io_din = 16'($urandom);
      end
      if (r >= 2 && r <= 4) io_rd = 1'b1;
      @(negedge clk);
    end
    io_wr = 1'b0; io_rd = 1'b0;
  endtask

  task automatic test_reset_mid();
    int unsigned n;
    logic [15:0] d;
    io_write(a_per(3), 16'd2);
    io_write(a_ctl(3), 16'h0003);
    io_write(ADDR_MASK, 16'h0008);
    n = 0;
    while (irq !== 1'b1 && n < 5 * MHZ) begin @(negedge clk); n++; end
    n_total++; if (irq !== 1'b1) $display("FAIL mid_irq_before: got %b want 1", irq); else n_pass++;
    #2;
    m_off = 0;
    rst = 1'b1;
    #1;
    n_total++; if (irq !== 1'b0) $display("FAIL mid_irq: got %b want 0", irq); else n_pass++;
    n_total++; if (io_dout !== 16'h0) $display("FAIL mid_dout: got %h want 0000", io_dout); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    io_read(a_ctl(3), d);
    n_total++; if (d !== 16'h0000) $display("FAIL mid_ch3_idle: got %h want 0000", d); else n_pass++;
    io_read(ADDR_PEND, d);
    n_total++; if (d !== 16'h0000) $display("FAIL mid_pend: got %h want 0000", d); else n_pass++;
    repeat (5 * MHZ) @(negedge clk);
    io_read(ADDR_PEND, d);
    n_total++; if (d !== 16'h0000) $display("FAIL mid_no_fire: got %h want 0000", d); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL mid_irq_after: got %b want 0", irq); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_zero_and_rearm();
    test_time_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
